// File: rtl/id_pipe_ctrl_pkg.sv
// Shared definitions for the decode-stage pipeline controller.
// Contents: immediate-format select encoding, RV32I base opcodes,
// and the stall FSM state type.
package id_pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    Imm_NONE = 3'd0,
    Imm_I    = 3'd1,
    Imm_S    = 3'd2,
    Imm_B    = 3'd3,
    Imm_J    = 3'd4,
    Imm_U    = 3'd5
  } imm_sel_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/id_opc_dec.sv
// Combinational opcode decoder for the ID stage.
// Ports:
//   opcode   in  7  instruction bits [6:0]
//   imm_sel  out 3  immediate format (Imm_* encoding)
//   rs1_used out 1  instruction reads rs1
//   rs2_used out 1  instruction reads rs2
module id_opc_dec
  import id_pipe_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] imm_sel,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    imm_sel  = Imm_NONE;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (opcode)
      OP: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OP_IMM, LOAD, JALR: begin
        imm_sel  = Imm_I;
        rs1_used = 1'b1;
      end
      STORE: begin
        imm_sel  = Imm_S;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      BRANCH: begin
        imm_sel  = Imm_B;
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      JAL:        imm_sel = Imm_J;
      LUI, AUIPC: imm_sel = Imm_U;
      default:    imm_sel = Imm_NONE;
    endcase
  end

endmodule

// File: rtl/id_pipe_ctrl.sv
// Decode-stage pipeline controller: IF/ID register, immediate-format
// decode, load-use stall sequencing, branch flush and perf counters.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   if_pc/if_inst/if_valid  fetch stage output
//   ex_rd/ex_is_load/ex_valid  EX-stage instruction for hazard check
//   ex_br_taken             taken branch/jump resolved in EX
//   id_pc/id_inst/id_valid  IF/ID register contents
//   imm_sel                 immediate format of id_inst
//   pc_hold/idex_bubble/if_flush  pipeline control (combinational)
//   stall_cnt/flush_cnt     wrapping performance counters
module id_pipe_ctrl
  import id_pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_inst,
  input  logic             if_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_valid,
  input  logic             ex_br_taken,
  output logic [31:0]      id_pc,
  output logic [31:0]      id_inst,
  output logic             id_valid,
  output logic [2:0]       imm_sel,
  output logic             pc_hold,
  output logic             idex_bubble,
  output logic             if_flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_e state;
  logic   rs1_used;
  logic   rs2_used;
  logic   lu_haz;
  logic   stall;

  id_opc_dec u_dec (
    .opcode   (id_inst[6:0]),
    .imm_sel  (imm_sel),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  always_comb begin
    lu_haz = id_valid && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
             ((rs1_used && (id_inst[19:15] == ex_rd)) ||
              (rs2_used && (id_inst[24:20] == ex_rd)));
  end

  // Hazard is only honoured from RUN: the stalled load has reached MEM
  // by the STALL cycle and is forwarded, so a second stall is never needed.
  // A flush overrides a simultaneous stall.
  always_comb begin
    stall       = (state == RUN) && lu_haz && !ex_br_taken;
    pc_hold     = stall;
    if_flush    = ex_br_taken;
    idex_bubble = stall || ex_br_taken;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= RUN;
      id_pc     <= '0;
      id_inst   <= NOP_INST;
      id_valid  <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (ex_br_taken) begin
        state    <= RUN;
        id_pc    <= if_pc;
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end else if (stall) begin
        state    <= STALL;
      end else begin
        state    <= RUN;
        id_pc    <= if_pc;
        id_inst  <= if_inst;
        id_valid <= if_valid;
      end
      if (pc_hold)  stall_cnt <= stall_cnt + 1'b1;
      if (if_flush) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_pipe_ctrl.sv
module tb_id_pipe_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] O_OP = 7'b0110011, O_IMM = 7'b0010011, O_LD = 7'b0000011,
                         O_ST = 7'b0100011, O_BR = 7'b1100011, O_JAL = 7'b1101111,
                         O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUI = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, if_inst;
  logic        if_valid;
  logic [4:0]  ex_rd;
  logic        ex_is_load, ex_valid, ex_br_taken;
  logic [31:0] id_pc, id_inst;
  logic        id_valid;
  logic [2:0]  imm_sel;
  logic        pc_hold, idex_bubble, if_flush;
  logic [31:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  // reference model state
  logic [31:0] m_pc, m_inst, m_scnt, m_fcnt;
  logic        m_valid, m_in_stall;
  // expected combinational outputs for the current cycle
  logic        e_hold, e_bubble, e_flush;
  logic [2:0]  e_imm;

  always #5 clk = ~clk;

  id_pipe_ctrl #(.NOP_INST(NOP), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_valid(ex_valid), .ex_br_taken(ex_br_taken),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid), .imm_sel(imm_sel),
    .pc_hold(pc_hold), .idex_bubble(idex_bubble), .if_flush(if_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'd0, rd, op};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    if (op == O_IMM || op == O_LD || op == O_JALR) return 3'd1;
    if (op == O_ST)  return 3'd2;
    if (op == O_BR)  return 3'd3;
    if (op == O_JAL) return 3'd4;
    if (op == O_LUI || op == O_AUI) return 3'd5;
    return 3'd0;
  endfunction

  function automatic bit reads_rs1(input logic [6:0] op);
    return op == O_OP || op == O_IMM || op == O_LD || op == O_ST || op == O_BR || op == O_JALR;
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op == O_OP || op == O_ST || op == O_BR;
  endfunction

  // drive one cycle's inputs and derive the expected control outputs
  task automatic apply(input logic rst, input logic [31:0] pc, input logic [31:0] inst,
                       input logic iv, input logic [4:0] rd, input logic ld,
                       input logic ev, input logic br);
    bit haz;
    @(negedge clk);
    rst_n = rst; if_pc = pc; if_inst = inst; if_valid = iv;
    ex_rd = rd; ex_is_load = ld; ex_valid = ev; ex_br_taken = br;
    #1;
    haz = m_valid && ev && ld && rd != 0 &&
          ((reads_rs1(m_inst[6:0]) && m_inst[19:15] == rd) ||
           (reads_rs2(m_inst[6:0]) && m_inst[24:20] == rd));
    e_flush  = br;
    e_hold   = haz && !m_in_stall && !br;
    e_bubble = e_hold || br;
    e_imm    = exp_imm(m_inst[6:0]);
  endtask

  // clock edge; update the model per the pipeline rules
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_pc = 0; m_inst = NOP; m_valid = 0; m_in_stall = 0; m_scnt = 0; m_fcnt = 0;
    end else begin
      if (e_hold)  m_scnt = m_scnt + 1;
      if (e_flush) m_fcnt = m_fcnt + 1;
      if (e_flush) begin
        m_pc = if_pc; m_inst = NOP; m_valid = 0; m_in_stall = 0;
      end else if (e_hold) begin
        m_in_stall = 1;
      end else begin
        m_pc = if_pc; m_inst = if_inst; m_valid = if_valid; m_in_stall = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      advance();
    end
    apply(1'b1, 32'h0, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (id_inst !== 32'h13) begin fails++; $display("FAIL reset_inst got %h exp %h", id_inst, 32'h13); end
    tests++; if (id_valid !== 1'b0 || id_pc !== 32'h0) begin fails++; $display("FAIL reset_valid_pc got %b/%h exp 0/0", id_valid, id_pc); end
    tests++; if (imm_sel !== 3'd1) begin fails++; $display("FAIL reset_imm got %0d exp 1", imm_sel); end
    tests++; if (stall_cnt !== 0 || flush_cnt !== 0) begin fails++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    tests++; if ({pc_hold, idex_bubble, if_flush} !== 3'b000) begin fails++; $display("FAIL reset_ctrl got %b exp 000", {pc_hold, idex_bubble, if_flush}); end
  endtask

  task automatic test_decode_sweep();
    logic [31:0] seq [6];
    logic [2:0]  want [6];
    seq[0] = mk(O_LD, 1, 2, 0);  want[0] = 3'd1;
    seq[1] = mk(O_ST, 0, 2, 3);  want[1] = 3'd2;
    seq[2] = mk(O_BR, 0, 2, 3);  want[2] = 3'd3;
    seq[3] = mk(O_JAL, 1, 0, 0); want[3] = 3'd4;
    seq[4] = mk(O_LUI, 4, 0, 0); want[4] = 3'd5;
    seq[5] = mk(O_OP, 6, 5, 7);  want[5] = 3'd0;
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 32'h100 + 4*i, seq[i], 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      advance();
      tests++; if (imm_sel !== want[i]) begin fails++; $display("FAIL decode_%0d got %0d exp %0d", i, imm_sel, want[i]); end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] add_i = mk(O_OP, 6, 5, 7);
    apply(1'b1, 32'h200, add_i, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h204, mk(O_OP, 8, 9, 10), 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    tests++; if ({pc_hold, idex_bubble, if_flush} !== 3'b110) begin fails++; $display("FAIL lu_ctrl got %b exp 110", {pc_hold, idex_bubble, if_flush}); end
    advance();
    tests++; if (id_inst !== add_i || id_pc !== 32'h200) begin fails++; $display("FAIL lu_hold got %h exp %h", id_inst, add_i); end
    tests++; if (stall_cnt !== m_scnt) begin fails++; $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, m_scnt); end
    // hazard inputs still present: must not stall a second cycle
    apply(1'b1, 32'h204, mk(O_OP, 8, 9, 10), 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    tests++; if ({pc_hold, idex_bubble} !== 2'b00) begin fails++; $display("FAIL lu_once got %b exp 00", {pc_hold, idex_bubble}); end
    advance();
    tests++; if (id_inst !== mk(O_OP, 8, 9, 10)) begin fails++; $display("FAIL lu_resume got %h exp %h", id_inst, mk(O_OP, 8, 9, 10)); end
  endtask

  task automatic test_no_false_stall();
    apply(1'b1, 32'h300, mk(O_OP, 6, 0, 0), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h304, mk(O_LUI, 5, 5, 5), 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    tests++; if (pc_hold !== 1'b0) begin fails++; $display("FAIL nfs_x0 got %b exp 0", pc_hold); end
    advance();
    apply(1'b1, 32'h308, mk(O_OP, 6, 5, 5), 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    tests++; if (pc_hold !== 1'b0) begin fails++; $display("FAIL nfs_lui got %b exp 0", pc_hold); end
    advance();
    apply(1'b1, 32'h30c, NOP, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0);
    tests++; if (pc_hold !== 1'b0) begin fails++; $display("FAIL nfs_nonload got %b exp 0", pc_hold); end
    advance();
  endtask

  task automatic test_flush_priority();
    do_reset();
    apply(1'b1, 32'h400, mk(O_OP, 6, 5, 7), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h404, mk(O_OP, 1, 2, 3), 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
    tests++; if ({pc_hold, idex_bubble, if_flush} !== 3'b011) begin fails++; $display("FAIL flush_ctrl got %b exp 011", {pc_hold, idex_bubble, if_flush}); end
    advance();
    tests++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'h404) begin fails++; $display("FAIL flush_ifid got %b/%h/%h exp 0/13/404", id_valid, id_inst, id_pc); end
    tests++; if (flush_cnt !== 32'd1 || stall_cnt !== 32'd0) begin fails++; $display("FAIL flush_cnt got %0d/%0d exp 1/0", flush_cnt, stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    apply(1'b1, 32'h500, mk(O_ST, 0, 3, 4), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h504, NOP, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
    advance();
    apply(1'b0, 32'h508, NOP, 1'b1, 5'd4, 1'b1, 1'b1, 1'b1);
    advance();
    tests++; if ({id_pc, id_inst, id_valid} !== {32'h0, NOP, 1'b0} || stall_cnt !== 0 || flush_cnt !== 0) begin
      fails++; $display("FAIL rst_mid got %h/%h/%b/%0d/%0d exp 0/13/0/0/0", id_pc, id_inst, id_valid, stall_cnt, flush_cnt);
    end
    apply(1'b1, 32'h0, NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] inst;
    ops[0] = O_OP; ops[1] = O_IMM; ops[2] = O_LD; ops[3] = O_ST; ops[4] = O_BR;
    ops[5] = O_JAL; ops[6] = O_JALR; ops[7] = O_LUI; ops[8] = O_AUI; ops[9] = 7'h7f;
    for (int i = 0; i < 400; i++) begin
      inst = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 9)];
      inst[19:15] = 5'($urandom_range(0, 5));
      inst[24:20] = 5'($urandom_range(0, 5));
      apply(1'b1, $urandom, inst, ($urandom_range(0, 4) != 0), 5'($urandom_range(0, 5)),
            ($urandom_range(0, 1) == 1), ($urandom_range(0, 5) != 0), ($urandom_range(0, 9) == 0));
      tests++; if ({pc_hold, idex_bubble, if_flush, imm_sel} !== {e_hold, e_bubble, e_flush, e_imm}) begin
        fails++; $display("FAIL rnd_ctrl[%0d] got %b exp %b", i, {pc_hold, idex_bubble, if_flush, imm_sel}, {e_hold, e_bubble, e_flush, e_imm});
      end
      advance();
      tests++; if ({id_pc, id_inst, id_valid, stall_cnt, flush_cnt} !== {m_pc, m_inst, m_valid, m_scnt, m_fcnt}) begin
        fails++; $display("FAIL rnd_state[%0d] got %h/%h/%b/%0d/%0d exp %h/%h/%b/%0d/%0d", i,
                          id_pc, id_inst, id_valid, stall_cnt, flush_cnt, m_pc, m_inst, m_valid, m_scnt, m_fcnt);
      end
    end
  endtask

  task automatic test_counter_wrap();
    apply(1'b1, 32'h600, mk(O_OP, 6, 5, 7), 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    advance();
    apply(1'b1, 32'h604, NOP, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    m_scnt = 32'hFFFF_FFFF;
    tests++; if (pc_hold !== 1'b1) begin fails++; $display("FAIL wrap_stall got %b exp 1", pc_hold); end
    advance();
    tests++; if (stall_cnt !== 32'd0) begin fails++; $display("FAIL wrap_cnt got %0d exp 0", stall_cnt); end
  endtask

  initial begin
    m_pc = 0; m_inst = NOP; m_valid = 0; m_in_stall = 0; m_scnt = 0; m_fcnt = 0;
    test_reset();
    test_decode_sweep();
    test_load_use();
    test_no_false_stall();
    test_flush_priority();
    test_reset_mid_stall();
    test_random();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
